// File: rtl/or1k_pic_pkg.sv
// Shared types and constants for the OR1K PIC interrupt arbiter.
package or1k_pic_pkg;

    localparam int IRQ_LINES = 32;
    localparam int IRQ_ID_W  = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } pic_arb_state_t;

    // Low 'width' bits set: these lines bypass the SR interrupt enable.
    function automatic logic [IRQ_LINES-1:0] nmi_mask(input int width);
        logic [IRQ_LINES-1:0] m;
        m = '0;
        for (int i = 0; i < IRQ_LINES; i++) begin
            if (i < width) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/or1k_prio_enc.sv
// Find-first-set over 32 lines, searching upward from base_i and wrapping 31 -> 0.
module or1k_prio_enc
    import or1k_pic_pkg::*;
(
    input  logic [IRQ_LINES-1:0] vec_i,
    input  logic [IRQ_ID_W-1:0]  base_i,
    output logic                 found_o,
    output logic [IRQ_ID_W-1:0]  idx_o
);

    logic [2*IRQ_LINES-1:0] dbl;
    logic [IRQ_LINES-1:0]   rot;

    assign dbl = {vec_i, vec_i};
    assign rot = dbl[base_i +: IRQ_LINES];

    // Scan downward so the lowest rotated position is the last to assign; index wraps in 5 bits.
    always_comb begin
        found_o = |rot;
        idx_o   = '0;
        for (int i = IRQ_LINES - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx_o = base_i + IRQ_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/or1k_pic_arbiter.sv
// Selects one pending PIC line and holds it through the req/ack/done handshake
// with the exception unit; non-maskable low lines always win.
module or1k_pic_arbiter
    import or1k_pic_pkg::*;
#(
    parameter int    OPTION_PIC_NMI_WIDTH = 0,
    parameter string OPTION_ARB_MODE      = "FIXED"
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IRQ_LINES-1:0] spr_picsr_i,
    input  logic                 sr_iee_i,
    output logic                 irq_req_o,
    output logic [IRQ_ID_W-1:0]  irq_id_o,
    output logic                 irq_nmi_o,
    input  logic                 irq_ack_i,
    input  logic                 irq_done_i,
    output logic                 irq_busy_o,
    output logic [7:0]           withdraw_cnt_o
);

    localparam logic [IRQ_LINES-1:0] NMI_MASK = nmi_mask(OPTION_PIC_NMI_WIDTH);
    localparam bit                   RR_MODE  = (OPTION_ARB_MODE == "ROUND_ROBIN");

    generate
        if (OPTION_ARB_MODE != "FIXED" && OPTION_ARB_MODE != "ROUND_ROBIN") begin : g_bad_mode
            $fatal(1, "or1k_pic_arbiter: OPTION_ARB_MODE must be FIXED or ROUND_ROBIN");
        end
        if (OPTION_PIC_NMI_WIDTH < 0 || OPTION_PIC_NMI_WIDTH > 31) begin : g_bad_nmi
            $fatal(1, "or1k_pic_arbiter: OPTION_PIC_NMI_WIDTH must be 0..31");
        end
    endgenerate

    pic_arb_state_t       state_q;
    logic                 irq_req_q;
    logic [IRQ_ID_W-1:0]  irq_id_q;
    logic                 irq_nmi_q;
    logic                 irq_busy_q;
    logic [7:0]           withdraw_cnt_q;
    logic [7:0]           withdraw_cnt_d;
    logic [IRQ_ID_W-1:0]  rr_ptr_q;

    logic [IRQ_LINES-1:0] eligible;
    logic [IRQ_LINES-1:0] nmi_vec;
    logic [IRQ_LINES-1:0] mask_vec;
    logic [IRQ_ID_W-1:0]  mask_base;
    logic                 nmi_found;
    logic                 mask_found;
    logic [IRQ_ID_W-1:0]  nmi_idx;
    logic [IRQ_ID_W-1:0]  mask_idx;
    logic                 any_eligible;
    logic [IRQ_ID_W-1:0]  sel_id;
    logic                 still_eligible;

    assign eligible  = spr_picsr_i & (sr_iee_i ? {IRQ_LINES{1'b1}} : NMI_MASK);
    assign nmi_vec   = eligible & NMI_MASK;
    assign mask_vec  = eligible & ~NMI_MASK;
    assign mask_base = RR_MODE ? rr_ptr_q : '0;

    or1k_prio_enc u_nmi_enc (
        .vec_i   (nmi_vec),
        .base_i  ('0),
        .found_o (nmi_found),
        .idx_o   (nmi_idx)
    );

    or1k_prio_enc u_mask_enc (
        .vec_i   (mask_vec),
        .base_i  (mask_base),
        .found_o (mask_found),
        .idx_o   (mask_idx)
    );

    assign any_eligible   = nmi_found | mask_found;
    assign sel_id         = nmi_found ? nmi_idx : mask_idx;
    assign still_eligible = spr_picsr_i[irq_id_q] & (sr_iee_i | irq_nmi_q);
    assign withdraw_cnt_d = (withdraw_cnt_q == 8'hFF) ? withdraw_cnt_q : withdraw_cnt_q + 8'd1;

    // Ack takes priority over withdraw; the latched ID is frozen outside IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            irq_req_q      <= 1'b0;
            irq_id_q       <= '0;
            irq_nmi_q      <= 1'b0;
            irq_busy_q     <= 1'b0;
            withdraw_cnt_q <= '0;
            rr_ptr_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_eligible) begin
                        state_q    <= REQ;
                        irq_req_q  <= 1'b1;
                        irq_busy_q <= 1'b1;
                        irq_id_q   <= sel_id;
                        irq_nmi_q  <= nmi_found;
                    end
                end
                REQ: begin
                    if (irq_ack_i) begin
                        state_q   <= SERVICE;
                        irq_req_q <= 1'b0;
                        rr_ptr_q  <= irq_id_q + 5'd1;
                    end else if (!still_eligible) begin
                        state_q        <= IDLE;
                        irq_req_q      <= 1'b0;
                        irq_busy_q     <= 1'b0;
                        withdraw_cnt_q <= withdraw_cnt_d;
                    end
                end
                SERVICE: begin
                    if (irq_done_i) begin
                        state_q    <= IDLE;
                        irq_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    irq_req_q  <= 1'b0;
                    irq_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq_req_o      = irq_req_q;
    assign irq_id_o       = irq_id_q;
    assign irq_nmi_o      = irq_nmi_q;
    assign irq_busy_o     = irq_busy_q;
    assign withdraw_cnt_o = withdraw_cnt_q;

endmodule

// File: tb/tb_or1k_pic_arbiter.sv
// Two arbiter instances (FIXED with 2 NMI lines, ROUND_ROBIN without NMIs) share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_or1k_pic_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] picsr;
    logic        iee;
    logic        ack;
    logic        done;

    logic        req  [2];
    logic [4:0]  id   [2];
    logic        nmi  [2];
    logic        busy [2];
    logic [7:0]  cnt  [2];

    int errors = 0;
    int checks = 0;
    bit checkEn = 1'b0;

    int nmiW   [2] = '{2, 0};
    bit rrMode [2] = '{1'b0, 1'b1};
    int expRr  [4] = '{0, 1, 31, 0};

    int mPhase [2] = '{0, 0};
    int mId    [2] = '{0, 0};
    bit mNmi   [2] = '{1'b0, 1'b0};
    int mPtr   [2] = '{0, 0};
    int mCnt   [2] = '{0, 0};

    always #5 clk = ~clk;

    or1k_pic_arbiter #(
        .OPTION_PIC_NMI_WIDTH (2),
        .OPTION_ARB_MODE      ("FIXED")
    ) dutFx (
        .clk            (clk),
        .rst_n          (rst_n),
        .spr_picsr_i    (picsr),
        .sr_iee_i       (iee),
        .irq_req_o      (req[0]),
        .irq_id_o       (id[0]),
        .irq_nmi_o      (nmi[0]),
        .irq_ack_i      (ack),
        .irq_done_i     (done),
        .irq_busy_o     (busy[0]),
        .withdraw_cnt_o (cnt[0])
    );

    or1k_pic_arbiter #(
        .OPTION_PIC_NMI_WIDTH (0),
        .OPTION_ARB_MODE      ("ROUND_ROBIN")
    ) dutRr (
        .clk            (clk),
        .rst_n          (rst_n),
        .spr_picsr_i    (picsr),
        .sr_iee_i       (iee),
        .irq_req_o      (req[1]),
        .irq_id_o       (id[1]),
        .irq_nmi_o      (nmi[1]),
        .irq_ack_i      (ack),
        .irq_done_i     (done),
        .irq_busy_o     (busy[1]),
        .withdraw_cnt_o (cnt[1])
    );

    // Winner rule: lowest pending NMI, else first pending maskable line from the search start.
    function automatic void pick(input int n, input logic [31:0] p, input logic ie,
                                 output bit found, output int sel, output bit isNmi);
        int start;
        int j;
        found = 1'b0;
        sel   = 0;
        isNmi = 1'b0;
        for (int i = 0; i < nmiW[n]; i++) begin
            if (!found && p[i]) begin
                found = 1'b1;
                sel   = i;
                isNmi = 1'b1;
            end
        end
        start = rrMode[n] ? mPtr[n] : 0;
        for (int k = 0; k < 32; k++) begin
            j = (start + k) % 32;
            if (!found && ie && j >= nmiW[n] && p[j]) begin
                found = 1'b1;
                sel   = j;
            end
        end
    endfunction

    bit mFound;
    int mSel;
    bit mIsNmi;

    // Phase 0 = waiting, 1 = request presented, 2 = handler running.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 2; n++) begin
                mPhase[n] = 0;
                mId[n]    = 0;
                mNmi[n]   = 1'b0;
                mPtr[n]   = 0;
                mCnt[n]   = 0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (mPhase[n] == 0) begin
                    pick(n, picsr, iee, mFound, mSel, mIsNmi);
                    if (mFound) begin
                        mPhase[n] = 1;
                        mId[n]    = mSel;
                        mNmi[n]   = mIsNmi;
                    end
                end else if (mPhase[n] == 1) begin
                    if (ack) begin
                        mPhase[n] = 2;
                        mPtr[n]   = (mId[n] + 1) % 32;
                    end else if (!(picsr[mId[n]] && (iee || mNmi[n]))) begin
                        mPhase[n] = 0;
                        if (mCnt[n] < 255) mCnt[n] = mCnt[n] + 1;
                    end
                end else begin
                    if (done) mPhase[n] = 0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int n, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s inst%0d: got %0h, expected %0h at %0t", name, n, got, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag, input int n, input bit eReq, input int eId,
                            input bit eNmi, input bit eBusy, input int eCnt);
        checkOutput({tag, ".req"},  n, 32'(req[n]),  32'(eReq));
        checkOutput({tag, ".id"},   n, 32'(id[n]),   32'(eId));
        checkOutput({tag, ".nmi"},  n, 32'(nmi[n]),  32'(eNmi));
        checkOutput({tag, ".busy"}, n, 32'(busy[n]), 32'(eBusy));
        checkOutput({tag, ".cnt"},  n, 32'(cnt[n]),  32'(eCnt));
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            for (int n = 0; n < 2; n++) begin
                checkOutput("model.req",  n, 32'(req[n]),  32'(mPhase[n] == 1));
                checkOutput("model.busy", n, 32'(busy[n]), 32'(mPhase[n] != 0));
                checkOutput("model.id",   n, 32'(id[n]),   32'(mId[n]));
                checkOutput("model.nmi",  n, 32'(nmi[n]),  32'(mNmi[n]));
                checkOutput("model.cnt",  n, 32'(cnt[n]),  32'(mCnt[n]));
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] p, input logic ie, input logic a, input logic d);
        picsr = p;
        iee   = ie;
        ack   = a;
        done  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        picsr = '0;
        iee   = 1'b0;
        ack   = 1'b0;
        done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 0, 0, 0, 0, 0, 0);
        checkAll("reset", 1, 0, 0, 0, 0, 0);
        checkEn = 1'b1;
        rst_n   = 1'b1;

        applyStimulus(32'h0000_0050, 1, 0, 0);
        checkAll("basic_req", 0, 1, 4, 0, 1, 0);
        checkAll("basic_req", 1, 1, 4, 0, 1, 0);
        checkOutput("pin.model_id", 0, 32'(mId[0]), 32'd4);
        applyStimulus(32'h0000_0050, 1, 1, 0);
        checkAll("basic_ack", 0, 0, 4, 0, 1, 0);
        applyStimulus(32'h0000_0000, 1, 0, 1);
        checkAll("basic_done", 0, 0, 4, 0, 0, 0);
        checkAll("basic_done", 1, 0, 4, 0, 0, 0);

        doReset();
        for (int r = 0; r < 4; r++) begin
            applyStimulus(32'h8000_0003, 1, 0, 0);
            checkAll("rr_grant", 1, 1, expRr[r], 0, 1, 0);
            checkAll("fixed_nmi_grant", 0, 1, 0, 1, 1, 0);
            applyStimulus(32'h8000_0003, 1, 1, 0);
            applyStimulus(32'h8000_0003, 1, 0, 1);
        end
        checkOutput("pin.model_ptr", 1, 32'(mPtr[1]), 32'd1);

        doReset();
        applyStimulus(32'h0000_0104, 0, 0, 0);
        checkAll("nmi_none", 0, 0, 0, 0, 0, 0);
        checkAll("nmi_none", 1, 0, 0, 0, 0, 0);
        applyStimulus(32'h0000_0106, 0, 0, 0);
        checkAll("nmi_grant", 0, 1, 1, 1, 1, 0);
        checkAll("nmi_masked", 1, 0, 0, 0, 0, 0);
        applyStimulus(32'h0000_0106, 0, 1, 0);
        applyStimulus(32'h0000_0000, 0, 0, 1);

        doReset();
        applyStimulus(32'h0000_0020, 1, 0, 0);
        checkAll("wd_req", 0, 1, 5, 0, 1, 0);
        applyStimulus(32'h0000_0000, 1, 0, 0);
        checkAll("wd_first", 0, 0, 5, 0, 0, 1);
        checkAll("wd_first", 1, 0, 5, 0, 0, 1);
        applyStimulus(32'h0000_0020, 1, 0, 0);
        applyStimulus(32'h0000_0021, 1, 0, 0);
        checkAll("hold_id", 0, 1, 5, 0, 1, 1);
        checkAll("hold_id", 1, 1, 5, 0, 1, 1);
        applyStimulus(32'h0000_0001, 1, 1, 0);
        checkAll("ack_beats_wd", 0, 0, 5, 0, 1, 1);
        checkAll("ack_beats_wd", 1, 0, 5, 0, 1, 1);
        applyStimulus(32'h0000_0000, 1, 0, 1);
        for (int r = 0; r < 299; r++) begin
            applyStimulus(32'h0000_0020, 1, 0, 0);
            applyStimulus(32'h0000_0000, 1, 0, 0);
        end
        checkAll("wd_sat", 0, 0, 5, 0, 0, 255);
        checkAll("wd_sat", 1, 0, 5, 0, 0, 255);

        applyStimulus(32'h0000_0020, 1, 0, 0);
        applyStimulus(32'h0000_0020, 1, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("async_rst", 0, 0, 0, 0, 0, 0);
        checkAll("async_rst", 1, 0, 0, 0, 0, 0);
        picsr = 32'h0000_0001;
        #3;
        rst_n = 1'b1;
        applyStimulus(32'h0000_0001, 1, 0, 0);
        checkAll("post_rst", 0, 1, 0, 1, 1, 0);
        checkAll("post_rst", 1, 1, 0, 0, 1, 0);
        applyStimulus(32'h0000_0001, 1, 1, 0);
        applyStimulus(32'h0000_0000, 1, 0, 1);

        for (int c = 0; c < 3000; c++) begin
            logic [31:0] p;
            p = picsr;
            if ($urandom_range(3) == 0) p = $urandom & $urandom & $urandom;
            applyStimulus(p, $urandom_range(3) != 0, $urandom_range(2) == 0, $urandom_range(2) == 0);
        end

        @(negedge clk);
        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
